// File: rtl/bgm_pkg.sv
// Shared definitions for the background-music sequencer: ROM word fields,
// reserved note codes and the playback state encoding.
package bgm_pkg;

   localparam int NOTE_W   = 6;
   localparam int DUR_W    = 6;
   localparam int CODE_MSB = 11;
   localparam int CODE_LSB = 6;
   localparam int DUR_MSB  = 5;
   localparam int DUR_LSB  = 0;

   localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
   localparam logic [NOTE_W-1:0] NOTE_END  = 6'd63;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_PLAY,
      ST_DONE
   } state_e;

endpackage

// File: rtl/bgm_beat_timer.sv
// Beat period counter: counts 0..BEAT_CYCLES-1 while not held and emits a
// one-cycle tick on the last count; clr restarts the beat from zero.
module bgm_beat_timer #(
   parameter int BEAT_CYCLES = 12500000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hold,
   output logic tick
);

   localparam int                CNT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BEAT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap = (r_cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (!hold) begin
         r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      end
   end

   assign tick = !clr && !hold && w_wrap;

endmodule

// File: rtl/bgm_sequencer.sv
// Background-music playback controller: fetches note entries from a ROM,
// holds each note for its duration in beats, and handles pause/stop/loop.
module bgm_sequencer
   import bgm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 12,
   parameter int BEAT_CYCLES = 12500000,
   parameter int START_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   input  logic                  loop_en,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [NOTE_W-1:0]     note_code,
   output logic                  note_valid,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_START = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;

   state_e                  r_state;
   state_e                  w_next;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [NOTE_W-1:0]       r_note;
   logic [DUR_W-1:0]        r_dur;

   logic [NOTE_W-1:0]       w_code;
   logic [DUR_W-1:0]        w_dur;
   logic                    w_tick;
   logic                    w_adv;
   logic                    w_last;
   logic                    w_end;

   assign w_code = rom_data[CODE_MSB:CODE_LSB];
   assign w_dur  = rom_data[DUR_MSB:DUR_LSB];

   bgm_beat_timer #(
      .BEAT_CYCLES (BEAT_CYCLES)
   ) u_beat_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (r_state != ST_PLAY),
      .hold (pause),
      .tick (w_tick)
   );

   // Advance to the next entry: a zero-length entry is skipped, or the last beat
   // of the current note expired. Advancing past the top address ends the song.
   assign w_adv  = ((r_state == ST_LATCH) && (w_code != NOTE_END) && (w_dur == '0)) ||
                   ((r_state == ST_PLAY) && w_tick && (r_dur == DUR_W'(1)));
   assign w_last = (r_addr == ADDR_MAX);
   assign w_end  = ((r_state == ST_LATCH) && (w_code == NOTE_END)) || (w_adv && w_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // NOTE: w_next gets a default before the case so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (start) w_next = ST_FETCH;
         ST_FETCH: w_next = ST_LATCH;
         ST_LATCH: w_next = ST_PLAY;
         ST_PLAY:  w_next = ST_PLAY;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      if (w_adv) w_next = ST_FETCH;
      if (w_end) w_next = loop_en ? ST_FETCH : ST_DONE;
      if (stop)  w_next = ST_IDLE;
   end

   // Note and address survive FETCH/LATCH of the next entry so there is no gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= ADDR_START;
         r_note <= NOTE_REST;
         r_dur  <= '0;
      end else if (stop) begin
         r_addr <= ADDR_START;
         r_note <= NOTE_REST;
      end else begin
         if ((r_state == ST_IDLE) && start) r_addr <= ADDR_START;
         if ((r_state == ST_LATCH) && !w_end && !w_adv) begin
            r_note <= w_code;
            r_dur  <= w_dur;
         end
         if (w_tick) r_dur <= r_dur - DUR_W'(1);
         if (w_adv && !w_last) r_addr <= r_addr + ADDR_WIDTH'(1);
         if (w_end) begin
            r_addr <= ADDR_START;
            if (!loop_en) r_note <= NOTE_REST;
         end
      end
   end

   always_comb begin
      rom_en     = (r_state == ST_FETCH);
      rom_addr   = r_addr;
      busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
      done       = (r_state == ST_DONE);
      note_code  = pause ? NOTE_REST : r_note;
      note_valid = (r_note != NOTE_REST) && !pause && busy;
   end

endmodule

// File: tb/tb_bgm_sequencer.sv
// Self-checking bench for bgm_sequencer: a song-level model expands ROM
// contents into an expected per-cycle trace that the DUT is compared against.
module tb_bgm_sequencer;

   localparam int BEAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        pause = 1'b0;
   logic        loop_en = 1'b0;
   logic        rom_en;
   logic [15:0] rom_addr;
   logic [11:0] rom_data = 12'h000;
   logic [5:0]  note_code;
   logic        note_valid;
   logic        busy;
   logic        done;

   logic [11:0] rom [256];
   int          n_checks = 0;
   int          n_pass = 0;

   typedef struct {
      logic [5:0]  note;
      logic        valid;
      logic        busy;
      logic        done;
      logic        ren;
      logic [15:0] addr;
      bit          p;
   } rec_t;

   rec_t exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr[7:0]];

   bgm_sequencer #(
      .ADDR_WIDTH  (16),
      .DATA_WIDTH  (12),
      .BEAT_CYCLES (BEAT),
      .START_ADDR  (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .loop_en    (loop_en),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .note_code  (note_code),
      .note_valid (note_valid),
      .busy       (busy),
      .done       (done)
   );

   function automatic void push(logic [5:0] note, bit bsy, bit dn, bit ren, logic [15:0] addr, bit p);
      rec_t r;
      r.note  = p ? 6'd0 : note;
      r.valid = (note != 6'd0) && !p && bsy;
      r.busy  = bsy;
      r.done  = dn;
      r.ren   = ren;
      r.addr  = addr;
      r.p     = p;
      exp_q.push_back(r);
   endfunction

   function automatic bit rnd_pause(int idx, int pct, int pfrom, int plen);
      return ((idx >= pfrom) && (idx < pfrom + plen)) || (int'($urandom_range(99)) < pct);
   endfunction

   // Song-level expansion: each entry costs one fetch and one latch cycle,
   // then dur*BEAT un-paused play cycles; the previous note keeps sounding
   // while the next entry is fetched.
   function automatic void build(bit loop, int pct, int pfrom, int plen, int max_len);
      logic [5:0]  note = 6'd0;
      logic [5:0]  code;
      logic [5:0]  dur;
      logic [15:0] addr = 16'd0;
      int          remaining;
      exp_q.delete();
      while (exp_q.size() < max_len) begin
         push(note, 1, 0, 1, addr, rnd_pause(exp_q.size(), pct, pfrom, plen));
         push(note, 1, 0, 0, addr, rnd_pause(exp_q.size(), pct, pfrom, plen));
         code = rom[addr[7:0]][11:6];
         dur  = rom[addr[7:0]][5:0];
         if (code == 6'd63) begin
            if (loop) begin
               addr = 16'd0;
               continue;
            end
            push(6'd0, 0, 1, 0, addr, 0);
            push(6'd0, 0, 0, 0, addr, 0);
            return;
         end
         if (dur == 6'd0) begin
            addr++;
            continue;
         end
         note = code;
         remaining = int'(dur) * BEAT;
         while (remaining > 0) begin
            bit p;
            p = rnd_pause(exp_q.size(), pct, pfrom, plen);
            push(note, 1, 0, 0, addr, p);
            if (!p) remaining--;
         end
         addr++;
      end
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 12'hFC0;
   endtask

   task automatic run_song(input string name, input bit loop, input int pct,
                           input int pfrom, input int plen, input int stop_at);
      build(loop, pct, pfrom, plen, (stop_at >= 0) ? stop_at + 1 : 2000);
      if (stop_at >= 0) begin
         while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
         push(6'd0, 0, 0, 0, 16'd0, 0);
      end
      loop_en = loop;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      foreach (exp_q[i]) begin
         pause = exp_q[i].p;
         stop  = (i == stop_at);
         start = (exp_q[i].busy || exp_q[i].done) && ($urandom_range(7) == 0);
         #1;
         n_checks++;
         if ({note_code, note_valid, busy, done, rom_en} !==
             {exp_q[i].note, exp_q[i].valid, exp_q[i].busy, exp_q[i].done, exp_q[i].ren}) begin
            $display("FAIL %s cyc %0d note/valid/busy/done/rom_en: got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                     name, i, note_code, note_valid, busy, done, rom_en,
                     exp_q[i].note, exp_q[i].valid, exp_q[i].busy, exp_q[i].done, exp_q[i].ren);
         end else begin
            n_pass++;
         end
         if (exp_q[i].ren) begin
            n_checks++;
            if (rom_addr !== exp_q[i].addr)
               $display("FAIL %s cyc %0d rom_addr: got %0d want %0d", name, i, rom_addr, exp_q[i].addr);
            else
               n_pass++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      pause = 1'b0;
      stop = 1'b0;
      loop_en = 1'b0;
   endtask

   task automatic check_idle_outputs(input string name);
      n_checks++;
      if ({note_code, note_valid, busy, done, rom_en, rom_addr} !== {6'd0, 4'b0000, 16'd0})
         $display("FAIL %s: note/valid/busy/done/rom_en/addr got %0d/%b/%b/%b/%b/%0d want 0/0/0/0/0/0",
                  name, note_code, note_valid, busy, done, rom_en, rom_addr);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset_idle");
   endtask

   task automatic test_basic();
      clear_rom();
      rom[0] = 12'h142;
      run_song("basic", 0, 0, 0, 0, -1);
   endtask

   task automatic test_loop_stop();
      clear_rom();
      rom[0] = 12'h142;
      run_song("loop_stop", 1, 0, 0, 0, 30);
   endtask

   task automatic test_skip();
      clear_rom();
      rom[0] = 12'h080;
      rom[1] = 12'h0C1;
      run_song("skip", 0, 0, 0, 0, -1);
   endtask

   task automatic test_rest();
      clear_rom();
      rom[0] = 12'h003;
      run_song("rest", 0, 0, 0, 0, -1);
   endtask

   task automatic test_pause();
      clear_rom();
      rom[0] = 12'h142;
      run_song("pause", 0, 0, 5, 6, -1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         int n;
         clear_rom();
         n = int'($urandom_range(5, 1));
         for (int e = 0; e < n; e++) begin
            logic [5:0] c;
            logic [5:0] d;
            c = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom_range(62, 1));
            d = 6'($urandom_range(3));
            rom[e] = {c, d};
         end
         rom[n] = {6'd63, 6'($urandom_range(63))};
         run_song("random", 0, 15, 0, 0, -1);
      end
      run_song("random_loop", 1, 10, 0, 0, int'($urandom_range(80, 40)));
   endtask

   task automatic test_async_reset();
      int waited;
      clear_rom();
      rom[0] = 12'h142;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (!note_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (!note_valid) $display("FAIL async_reset_setup: note_valid got 0 want 1 within 20 cycles");
      else n_pass++;
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("async_reset");
      @(negedge clk);
      rst = 1'b0;
      run_song("after_reset", 0, 0, 0, 0, -1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_loop_stop();
      test_skip();
      test_rest();
      test_pause();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
